// File: rtl/ysyx_23060077_riscv_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060077_riscv_pkg
// Shared definitions for the ysyx_23060077 RV64 core ID/EX boundary:
//   - default widths (data/PC, ALU opcode, register index)
//   - ALU opcode encoding shared with the EX ALU
//   - ALU A/B operand select encodings
//   - ID/EX slot state type
//   - reg_match(): "writer targets this source" test (x0 never matches)
// ---------------------------------------------------------------------------
package ysyx_23060077_riscv_pkg;

  localparam int unsigned RV_DATA_WIDTH     = 64;
  localparam int unsigned RV_ALU_OPT_WIDTH  = 4;
  localparam int unsigned RV_REG_ADDR_WIDTH = 5;

  localparam logic [RV_ALU_OPT_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [RV_ALU_OPT_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [RV_ALU_OPT_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [RV_ALU_OPT_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [RV_ALU_OPT_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [RV_ALU_OPT_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [RV_ALU_OPT_WIDTH-1:0] ALU_OR   = 4'd6;
  localparam logic [RV_ALU_OPT_WIDTH-1:0] ALU_AND  = 4'd7;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  function automatic logic reg_match(
    input logic                         wen,
    input logic [RV_REG_ADDR_WIDTH-1:0] wr_addr,
    input logic [RV_REG_ADDR_WIDTH-1:0] rs_addr
  );
    return wen && (wr_addr != '0) && (wr_addr == rs_addr);
  endfunction

endpackage

// File: rtl/ysyx_23060077_riscv_fwd_sel.sv
// ---------------------------------------------------------------------------
// ysyx_23060077_riscv_fwd_sel
// Source-operand resolver, one instance per rs.
// Config macro: YSYX_23060077_FORWARD_EN
//   defined    : MEM match -> mem data (stall if load), else WB match -> wb
//                data, else regfile data.
//   undefined  : regfile data only; stall while MEM or WB targets this rs.
// Ports:
//   i_used                          operand is actually consumed
//   i_rs_addr / i_rs_data           source index and regfile read data
//   i_mem_rd_wen/_is_load/_addr/_data  MEM-stage writer
//   i_wb_rd_wen/_addr/_data         WB-stage writer
//   o_data                          resolved operand
//   o_stall                         operand not yet available
// ---------------------------------------------------------------------------
module ysyx_23060077_riscv_fwd_sel
  import ysyx_23060077_riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = RV_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = RV_REG_ADDR_WIDTH
) (
  input  logic                      i_used,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [DATA_WIDTH-1:0]     i_rs_data,
  input  logic                      i_mem_rd_wen,
  input  logic                      i_mem_rd_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_mem_rd_data,
  input  logic                      i_wb_rd_wen,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_wb_rd_data,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_stall
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_used && reg_match(i_mem_rd_wen, i_mem_rd_addr, i_rs_addr);
  assign w_wb_hit  = i_used && reg_match(i_wb_rd_wen, i_wb_rd_addr, i_rs_addr);

`ifdef YSYX_23060077_FORWARD_EN
  // MEM is the younger writer, so it wins over WB.
  always_comb begin
    o_data = i_rs_data;
    if (w_mem_hit) begin
      o_data = i_mem_rd_data;
    end else if (w_wb_hit) begin
      o_data = i_wb_rd_data;
    end
  end

  // Load data is not available until the load reaches WB.
  assign o_stall = w_mem_hit && i_mem_rd_is_load;
`else
  assign o_data  = i_rs_data;
  // Regfile is written on the WB edge; wait until the writer has left WB.
  assign o_stall = w_mem_hit || w_wb_hit;

  logic w_unused;
  assign w_unused = ^{i_mem_rd_is_load, i_mem_rd_data, i_wb_rd_data};
`endif

endmodule

// File: rtl/ysyx_23060077_riscv_id_ex_stage.sv
// ---------------------------------------------------------------------------
// ysyx_23060077_riscv_id_ex_stage
// Single-entry ID/EX pipeline register of the RV64 core. Resolves operands
// (forwarding via ysyx_23060077_riscv_fwd_sel), selects ALU A (rs1/PC) and
// B (rs2/imm), owns RAW-hazard stalling and flush squashing for the slot.
// Config macro: YSYX_23060077_FORWARD_EN (see fwd_sel).
// Ports:
//   clk, rst                        clock, async active-high reset
//   id_valid/id_ready               ID handshake
//   id_pc, id_alu_opt, id_rs*_addr/data, id_imm, id_a_sel, id_b_sel,
//   id_rd_addr, id_rd_wen           decoded instruction
//   flush                           squash held and incoming instruction
//   mem_rd_*, wb_rd_*               downstream writers for forward/stall
//   ex_valid/ex_ready               EX handshake
//   alu_opt, alu_a_data, alu_b_data, ex_pc, ex_rd_addr, ex_rd_wen  payload
// ---------------------------------------------------------------------------
module ysyx_23060077_riscv_id_ex_stage
  import ysyx_23060077_riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = RV_DATA_WIDTH,
  parameter int unsigned ALU_OPT_WIDTH  = RV_ALU_OPT_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = RV_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [ALU_OPT_WIDTH-1:0]  id_alu_opt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      id_a_sel,
  input  logic                      id_b_sel,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_rd_wen,
  input  logic                      flush,
  input  logic                      mem_rd_wen,
  input  logic                      mem_rd_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  input  logic                      wb_rd_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     wb_rd_data,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [ALU_OPT_WIDTH-1:0]  alu_opt,
  output logic [DATA_WIDTH-1:0]     alu_a_data,
  output logic [DATA_WIDTH-1:0]     alu_b_data,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic                      ex_rd_wen
);

  slot_state_e r_state;
  slot_state_e w_state_nxt;

  logic [ALU_OPT_WIDTH-1:0]  r_alu_opt;
  logic [DATA_WIDTH-1:0]     r_a_data;
  logic [DATA_WIDTH-1:0]     r_b_data;
  logic [DATA_WIDTH-1:0]     r_pc;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
  logic                      r_rd_wen;

  logic                  w_rs1_used;
  logic                  w_rs2_used;
  logic [DATA_WIDTH-1:0] w_rs1_val;
  logic [DATA_WIDTH-1:0] w_rs2_val;
  logic                  w_rs1_stall;
  logic                  w_rs2_stall;
  logic                  w_full;
  logic                  w_hazard;
  logic                  w_capture;
  logic                  w_leave;

  assign w_rs1_used = (id_a_sel == A_SEL_RS1);
  assign w_rs2_used = (id_b_sel == B_SEL_RS2);

  ysyx_23060077_riscv_fwd_sel #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .i_used           (w_rs1_used),
    .i_rs_addr        (id_rs1_addr),
    .i_rs_data        (id_rs1_data),
    .i_mem_rd_wen     (mem_rd_wen),
    .i_mem_rd_is_load (mem_rd_is_load),
    .i_mem_rd_addr    (mem_rd_addr),
    .i_mem_rd_data    (mem_rd_data),
    .i_wb_rd_wen      (wb_rd_wen),
    .i_wb_rd_addr     (wb_rd_addr),
    .i_wb_rd_data     (wb_rd_data),
    .o_data           (w_rs1_val),
    .o_stall          (w_rs1_stall)
  );

  ysyx_23060077_riscv_fwd_sel #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .i_used           (w_rs2_used),
    .i_rs_addr        (id_rs2_addr),
    .i_rs_data        (id_rs2_data),
    .i_mem_rd_wen     (mem_rd_wen),
    .i_mem_rd_is_load (mem_rd_is_load),
    .i_mem_rd_addr    (mem_rd_addr),
    .i_mem_rd_data    (mem_rd_data),
    .i_wb_rd_wen      (wb_rd_wen),
    .i_wb_rd_addr     (wb_rd_addr),
    .i_wb_rd_data     (wb_rd_data),
    .o_data           (w_rs2_val),
    .o_stall          (w_rs2_stall)
  );

  assign w_full = (r_state == ST_FULL);

  // Held writer's result does not exist yet; wait until it moves to MEM.
  assign w_hazard = w_full &&
                    ((w_rs1_used && reg_match(r_rd_wen, r_rd_addr, id_rs1_addr)) ||
                     (w_rs2_used && reg_match(r_rd_wen, r_rd_addr, id_rs2_addr)));

  assign id_ready  = !w_hazard && !w_rs1_stall && !w_rs2_stall && (!w_full || ex_ready);
  assign w_capture = id_valid && id_ready && !flush;
  assign w_leave   = w_full && ex_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_capture) begin
      w_state_nxt = ST_FULL;
    end else if (w_leave) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_opt <= '0;
      r_a_data  <= '0;
      r_b_data  <= '0;
      r_pc      <= '0;
      r_rd_addr <= '0;
      r_rd_wen  <= 1'b0;
    end else if (w_capture) begin
      r_alu_opt <= id_alu_opt;
      r_a_data  <= (id_a_sel == A_SEL_PC)  ? id_pc  : w_rs1_val;
      r_b_data  <= (id_b_sel == B_SEL_IMM) ? id_imm : w_rs2_val;
      r_pc      <= id_pc;
      r_rd_addr <= id_rd_addr;
      r_rd_wen  <= id_rd_wen;
    end
  end

  assign ex_valid   = w_full;
  assign alu_opt    = r_alu_opt;
  assign alu_a_data = r_a_data;
  assign alu_b_data = r_b_data;
  assign ex_pc      = r_pc;
  assign ex_rd_addr = r_rd_addr;
  assign ex_rd_wen  = r_rd_wen;

endmodule

// File: tb/tb_ysyx_23060077_riscv_id_ex_stage.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060077_riscv_id_ex_stage. Follows the same
// YSYX_23060077_FORWARD_EN setting as the design build.
// ---------------------------------------------------------------------------
module tb_ysyx_23060077_riscv_id_ex_stage;
  import ysyx_23060077_riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [3:0]  id_alu_opt;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic [63:0] id_rs1_data, id_rs2_data;
  logic [63:0] id_imm;
  logic        id_a_sel, id_b_sel;
  logic [4:0]  id_rd_addr;
  logic        id_rd_wen;
  logic        flush;
  logic        mem_rd_wen, mem_rd_is_load;
  logic [4:0]  mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        wb_rd_wen;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_rd_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  alu_opt;
  logic [63:0] alu_a_data, alu_b_data, ex_pc;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_wen;

  always #5 clk = ~clk;

  ysyx_23060077_riscv_id_ex_stage #(
    .DATA_WIDTH     (64),
    .ALU_OPT_WIDTH  (4),
    .REG_ADDR_WIDTH (5)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_alu_opt(id_alu_opt),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
    .flush(flush),
    .mem_rd_wen(mem_rd_wen), .mem_rd_is_load(mem_rd_is_load),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .wb_rd_wen(wb_rd_wen), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_opt(alu_opt),
    .alu_a_data(alu_a_data), .alu_b_data(alu_b_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the instruction held in the slot, if any.
  logic        m_valid;
  logic [3:0]  m_opt;
  logic [63:0] m_a, m_b, m_pc;
  logic [4:0]  m_rd;
  logic        m_wen;
  logic        e_ready;   // model's id_ready for the last cycle
  logic        o_ready;   // DUT id_ready sampled in the last cycle

  // Operand value and availability from the architectural rules.
  function automatic void src_model(input logic used, input logic [4:0] rs, input logic [63:0] rf,
                                    output logic [63:0] val, output logic stall);
    val   = rf;
    stall = 1'b0;
    if (used && rs != 5'd0) begin
`ifdef YSYX_23060077_FORWARD_EN
      if (mem_rd_wen && mem_rd_addr == rs) begin
        val   = mem_rd_data;
        stall = mem_rd_is_load;
      end else if (wb_rd_wen && wb_rd_addr == rs) begin
        val = wb_rd_data;
      end
`else
      if ((mem_rd_wen && mem_rd_addr == rs) || (wb_rd_wen && wb_rd_addr == rs)) stall = 1'b1;
`endif
    end
  endfunction

  // One clock: sample id_ready mid-cycle, advance the model at the edge.
  task automatic tick();
    logic [63:0] va, vb;
    logic        sa, sb, hz, cap;
    @(negedge clk);
    src_model(!id_a_sel, id_rs1_addr, id_rs1_data, va, sa);
    src_model(!id_b_sel, id_rs2_addr, id_rs2_data, vb, sb);
    hz = m_valid && m_wen && m_rd != 5'd0 &&
         ((!id_a_sel && id_rs1_addr == m_rd) || (!id_b_sel && id_rs2_addr == m_rd));
    e_ready = !hz && !sa && !sb && (!m_valid || ex_ready);
    o_ready = id_ready;
    cap = id_valid && e_ready && !flush;
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
    end else if (cap) begin
      m_valid = 1'b1;
      m_opt   = id_alu_opt;
      m_a     = id_a_sel ? id_pc : va;
      m_b     = id_b_sel ? id_imm : vb;
      m_pc    = id_pc;
      m_rd    = id_rd_addr;
      m_wen   = id_rd_wen;
    end else if (m_valid && ex_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_pc = '0; id_alu_opt = '0; id_rs1_addr = '0; id_rs2_addr = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_a_sel = 0; id_b_sel = 0;
    id_rd_addr = '0; id_rd_wen = 0; flush = 0;
    mem_rd_wen = 0; mem_rd_is_load = 0; mem_rd_addr = '0; mem_rd_data = '0;
    wb_rd_wen = 0; wb_rd_addr = '0; wb_rd_data = '0; ex_ready = 1;
  endtask

  task automatic set_instr(input logic [3:0] opt, input logic [63:0] pc,
                           input logic [4:0] rs1, input logic [63:0] d1,
                           input logic [4:0] rs2, input logic [63:0] d2,
                           input logic [63:0] imm, input logic asel, input logic bsel,
                           input logic [4:0] rd, input logic wen);
    id_valid = 1; id_alu_opt = opt; id_pc = pc; id_rs1_addr = rs1; id_rs1_data = d1;
    id_rs2_addr = rs2; id_rs2_data = d2; id_imm = imm; id_a_sel = asel; id_b_sel = bsel;
    id_rd_addr = rd; id_rd_wen = wen;
  endtask

  task automatic drain();
    set_idle();
    tick();
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; m_valid = 0; m_opt = '0; m_a = '0; m_b = '0; m_pc = '0; m_rd = '0; m_wen = 0;
    #12;
    n_cmp++;
    if ({ex_valid, alu_opt, alu_a_data, alu_b_data, ex_pc, ex_rd_addr, ex_rd_wen} !== '0)
      begin n_bad++; $display("FAIL reset_state: got valid=%b a=%h b=%h pc=%h, need all 0", ex_valid, alu_a_data, alu_b_data, ex_pc); end
    rst = 0;
    // Fill the slot and stall EX, then reset mid-stall.
    set_instr(ALU_ADD, 64'h8000_0000, 5'd1, 64'h1111, 5'd2, 64'h2222, 64'h5, 0, 0, 5'd3, 1);
    ex_ready = 0;
    tick();
    id_valid = 0;
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL reset_prefill: ex_valid got %b need 1", ex_valid); end
    #2 rst = 1;
    #1;
    m_valid = 0;
    n_cmp++;
    if ({ex_valid, alu_opt, alu_a_data, alu_b_data, ex_pc, ex_rd_addr, ex_rd_wen} !== '0)
      begin n_bad++; $display("FAIL reset_midstall: got valid=%b a=%h b=%h pc=%h, need all 0", ex_valid, alu_a_data, alu_b_data, ex_pc); end
    rst = 0;
    ex_ready = 1;
    set_instr(ALU_SUB, 64'h8000_0010, 5'd4, 64'hABCD, 5'd5, 64'h1, 64'h0, 0, 0, 5'd6, 1);
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1 || alu_a_data !== 64'hABCD || alu_opt !== ALU_SUB)
      begin n_bad++; $display("FAIL reset_recapture: valid=%b a=%h opt=%h need 1/abcd/%h", ex_valid, alu_a_data, alu_opt, ALU_SUB); end
    drain();
  endtask

  task automatic test_back_to_back();
    set_idle();
    for (int i = 0; i < 4; i++) begin
      set_instr(ALU_ADD, 64'h1000 + 64'(4 * i), 5'd1, 64'h100 + 64'(i), 5'd0, 64'h0, 64'h7FF, 0, 1, 5'(10 + i), 1);
      tick();
      n_cmp++;
      if (o_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b need 1", i, o_ready); end
      n_cmp++;
      if (ex_valid !== 1'b1 || alu_b_data !== 64'h7FF || alu_a_data !== 64'h100 + 64'(i))
        begin n_bad++; $display("FAIL b2b_payload[%0d]: valid=%b a=%h b=%h need 1/%h/7ff", i, ex_valid, alu_a_data, alu_b_data, 64'h100 + 64'(i)); end
    end
    drain();
  endtask

  task automatic test_raw();
    set_idle();
    set_instr(ALU_ADD, 64'h2000, 5'd1, 64'h10, 5'd2, 64'h20, 64'h0, 0, 0, 5'd5, 1);
    tick();
    set_instr(ALU_SUB, 64'h2004, 5'd5, 64'hDEAD, 5'd3, 64'h3, 64'h0, 0, 0, 5'd6, 1);
    tick();
    n_cmp++;
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL raw_held_stall: id_ready got %b need 0", o_ready); end
    mem_rd_wen = 1; mem_rd_addr = 5'd5; mem_rd_data = 64'h1234;
    tick();
`ifdef YSYX_23060077_FORWARD_EN
    n_cmp++;
    if (o_ready !== 1'b1) begin n_bad++; $display("FAIL raw_mem_ready: id_ready got %b need 1", o_ready); end
`else
    n_cmp++;
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL raw_mem_stall: id_ready got %b need 0", o_ready); end
    mem_rd_wen = 0; wb_rd_wen = 1; wb_rd_addr = 5'd5; wb_rd_data = 64'h1234;
    tick();
    n_cmp++;
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL raw_wb_stall: id_ready got %b need 0", o_ready); end
    wb_rd_wen = 0; id_rs1_data = 64'h1234;
    tick();
    n_cmp++;
    if (o_ready !== 1'b1) begin n_bad++; $display("FAIL raw_rf_ready: id_ready got %b need 1", o_ready); end
`endif
    n_cmp++;
    if (ex_valid !== 1'b1 || alu_a_data !== 64'h1234 || alu_b_data !== 64'h3 || alu_opt !== ALU_SUB)
      begin n_bad++; $display("FAIL raw_operand: valid=%b a=%h b=%h opt=%h need 1/1234/3/%h", ex_valid, alu_a_data, alu_b_data, alu_opt, ALU_SUB); end
    drain();
  endtask

  task automatic test_load_use();
    set_idle();
    mem_rd_wen = 1; mem_rd_is_load = 1; mem_rd_addr = 5'd7; mem_rd_data = 64'hFFFF;
    set_instr(ALU_OR, 64'h3000, 5'd7, 64'h5555, 5'd0, 64'h0, 64'h40, 0, 1, 5'd8, 1);
    tick();
    n_cmp++;
    if (o_ready !== 1'b0 || ex_valid !== 1'b0)
      begin n_bad++; $display("FAIL load_use_stall: id_ready=%b ex_valid=%b need 0/0", o_ready, ex_valid); end
    mem_rd_wen = 0; mem_rd_is_load = 0; wb_rd_wen = 1; wb_rd_addr = 5'd7; wb_rd_data = 64'h7777;
    tick();
`ifndef YSYX_23060077_FORWARD_EN
    n_cmp++;
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL load_wb_stall: id_ready got %b need 0", o_ready); end
    wb_rd_wen = 0; id_rs1_data = 64'h7777;
    tick();
`endif
    n_cmp++;
    if (o_ready !== 1'b1 || ex_valid !== 1'b1 || alu_a_data !== 64'h7777 || alu_b_data !== 64'h40)
      begin n_bad++; $display("FAIL load_operand: ready=%b valid=%b a=%h b=%h need 1/1/7777/40", o_ready, ex_valid, alu_a_data, alu_b_data); end
    drain();
  endtask

  task automatic test_priority_x0();
    set_idle();
    mem_rd_wen = 1; mem_rd_addr = 5'd9; mem_rd_data = 64'hAA;
    wb_rd_wen  = 1; wb_rd_addr  = 5'd9; wb_rd_data  = 64'hBB;
    set_instr(ALU_XOR, 64'h4000, 5'd0, 64'h0, 5'd9, 64'hCC, 64'h0, 1, 0, 5'd11, 1);
    tick();
`ifdef YSYX_23060077_FORWARD_EN
    n_cmp++;
    if (ex_valid !== 1'b1 || alu_b_data !== 64'hAA || alu_a_data !== 64'h4000)
      begin n_bad++; $display("FAIL mem_over_wb: valid=%b a=%h b=%h need 1/4000/aa", ex_valid, alu_a_data, alu_b_data); end
`else
    n_cmp++;
    if (o_ready !== 1'b0 || ex_valid !== 1'b0)
      begin n_bad++; $display("FAIL x9_pending_stall: ready=%b valid=%b need 0/0", o_ready, ex_valid); end
`endif
    drain();
    // Writers to x0 and a held x0 destination must never interfere.
    mem_rd_wen = 1; mem_rd_addr = 5'd0; mem_rd_data = 64'hAA;
    wb_rd_wen  = 1; wb_rd_addr  = 5'd0; wb_rd_data  = 64'hBB;
    set_instr(ALU_AND, 64'h4100, 5'd0, 64'h11, 5'd0, 64'h22, 64'h0, 0, 0, 5'd0, 1);
    tick();
    n_cmp++;
    if (o_ready !== 1'b1 || ex_valid !== 1'b1 || alu_a_data !== 64'h11 || alu_b_data !== 64'h22)
      begin n_bad++; $display("FAIL x0_no_fwd: ready=%b valid=%b a=%h b=%h need 1/1/11/22", o_ready, ex_valid, alu_a_data, alu_b_data); end
    ex_ready = 0;
    set_instr(ALU_ADD, 64'h4104, 5'd0, 64'h33, 5'd0, 64'h44, 64'h0, 0, 0, 5'd12, 1);
    ex_ready = 1;
    tick();
    n_cmp++;
    if (o_ready !== 1'b1 || alu_a_data !== 64'h33 || alu_b_data !== 64'h44)
      begin n_bad++; $display("FAIL x0_no_hazard: ready=%b a=%h b=%h need 1/33/44", o_ready, alu_a_data, alu_b_data); end
    drain();
  endtask

  task automatic test_ex_stall_flush();
    set_idle();
    set_instr(ALU_SLT, 64'h5000, 5'd1, 64'h9999, 5'd2, 64'h8888, 64'h0, 0, 0, 5'd13, 1);
    tick();
    ex_ready = 0;
    set_instr(ALU_SLL, 64'h5004, 5'd3, 64'h1, 5'd4, 64'h2, 64'h0, 0, 0, 5'd14, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({ex_valid, alu_opt, alu_a_data, alu_b_data, ex_pc, ex_rd_addr, ex_rd_wen} !==
          {1'b1, ALU_SLT, 64'h9999, 64'h8888, 64'h5000, 5'd13, 1'b1})
        begin n_bad++; $display("FAIL ex_stall_hold[%0d]: valid=%b opt=%h a=%h b=%h pc=%h rd=%0d", i, ex_valid, alu_opt, alu_a_data, alu_b_data, ex_pc, ex_rd_addr); end
    end
    flush = 1;
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_full: ex_valid got %b need 0", ex_valid); end
    // Empty slot with flush: id_ready may be high, but nothing is captured.
    ex_ready = 1;
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty: ex_valid got %b need 0", ex_valid); end
    flush = 0; id_valid = 0;
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_squashed_seen: ex_valid got %b need 0", ex_valid); end
    drain();
  endtask

  task automatic test_random();
    logic [3:0] opts [8];
    opts[0] = ALU_ADD; opts[1] = ALU_SUB; opts[2] = ALU_SLL; opts[3] = ALU_SLT;
    opts[4] = ALU_SLTU; opts[5] = ALU_XOR; opts[6] = ALU_OR; opts[7] = ALU_AND;
    for (int i = 0; i < 600; i++) begin
      id_valid       = ($urandom_range(3) != 0);
      id_pc          = {$urandom, $urandom};
      id_alu_opt     = opts[$urandom_range(7)];
      id_rs1_addr    = 5'($urandom_range(3));
      id_rs2_addr    = 5'($urandom_range(3));
      id_rs1_data    = {$urandom, $urandom};
      id_rs2_data    = {$urandom, $urandom};
      id_imm         = {$urandom, $urandom};
      id_a_sel       = ($urandom_range(3) == 0);
      id_b_sel       = ($urandom_range(2) == 0);
      id_rd_addr     = 5'($urandom_range(3));
      id_rd_wen      = ($urandom_range(3) != 0);
      flush          = ($urandom_range(11) == 0);
      ex_ready       = ($urandom_range(3) != 0);
      mem_rd_wen     = ($urandom_range(2) == 0);
      mem_rd_is_load = ($urandom_range(3) == 0);
      mem_rd_addr    = 5'($urandom_range(3));
      mem_rd_data    = {$urandom, $urandom};
      wb_rd_wen      = ($urandom_range(2) == 0);
      wb_rd_addr     = 5'($urandom_range(3));
      wb_rd_data     = {$urandom, $urandom};
      tick();
      n_cmp++;
      if (o_ready !== e_ready) begin n_bad++; $display("FAIL rand_ready[%0d]: got %b need %b", i, o_ready, e_ready); end
      n_cmp++;
      if (ex_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b need %b", i, ex_valid, m_valid); end
      if (m_valid) begin
        n_cmp++;
        if ({alu_opt, alu_a_data, alu_b_data, ex_pc, ex_rd_addr, ex_rd_wen} !== {m_opt, m_a, m_b, m_pc, m_rd, m_wen})
          begin n_bad++; $display("FAIL rand_payload[%0d]: got %h/%h/%h/%h/%0d/%b need %h/%h/%h/%h/%0d/%b", i, alu_opt, alu_a_data, alu_b_data, ex_pc, ex_rd_addr, ex_rd_wen, m_opt, m_a, m_b, m_pc, m_rd, m_wen); end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw();
    test_load_use();
    test_priority_x0();
    test_ex_stall_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_riscv_id_ex_stage.md
# ysyx_23060077_riscv_id_ex_stage

ID/EX boundary stage of the ysyx_23060077 RV64 core. It accepts one decoded instruction per handshake from ID and resolves source operands, forwarding from MEM and WB when enabled. It selects ALU A/B inputs (rs1/PC, rs2/imm) and holds them in a single-entry pipeline register. It presents `alu_opt`/`alu_a_data`/`alu_b_data` directly to the EX ALU under a valid/ready handshake, and it owns RAW-hazard stalling and branch-flush squashing for that slot.

## Interface
- DATA_WIDTH, 64, operand/PC width
- ALU_OPT_WIDTH, 4, ALU opcode width (shared define encoding)
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid / id_ready  in / out  1  ID-side handshake
- id_pc  in  DATA_WIDTH  instruction PC
- id_alu_opt  in  ALU_OPT_WIDTH  ALU operation
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_WIDTH  source indices
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  regfile read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_a_sel  in  1  0 = rs1, 1 = PC
- id_b_sel  in  1  0 = rs2, 1 = imm
- id_rd_addr  in  REG_ADDR_WIDTH  destination index
- id_rd_wen  in  1  destination write enable
- flush  in  1  redirect; squash held and incoming instruction
- mem_rd_wen, mem_rd_is_load  in  1  MEM-stage writer info
- mem_rd_addr  in  REG_ADDR_WIDTH, mem_rd_data  in  DATA_WIDTH
- wb_rd_wen  in  1, wb_rd_addr  in  REG_ADDR_WIDTH, wb_rd_data  in  DATA_WIDTH
- ex_valid / ex_ready  out / in  1  EX-side handshake
- alu_opt  out  ALU_OPT_WIDTH, alu_a_data / alu_b_data  out  DATA_WIDTH
- ex_pc  out  DATA_WIDTH, ex_rd_addr  out  REG_ADDR_WIDTH, ex_rd_wen  out  1

## Operation
- States: EMPTY (ex_valid=0) and FULL (ex_valid=1). All payload outputs are registered.
- Capture on `id_valid & id_ready & !flush`. The state becomes FULL and the operands are latched.
- Leave on `ex_valid & ex_ready`. Capture and leave may occur in the same cycle; the state stays FULL with the new payload.
- Hazard against the held entry: held `ex_rd_wen`, `ex_rd_addr != 0`, and the address equals a used rs. A rs is used when its select is 0.
- `id_ready = !hazard & (EMPTY | ex_ready)`. A hazard stall lasts exactly until the held entry leaves plus one cycle, at which point the writer is in MEM.
- Forward mux per used rs:
  - MEM match (wen, addr≠0, addr equal) → mem_rd_data; if mem_rd_is_load, stall instead.
  - Otherwise WB match → wb_rd_data.
  - Otherwise regfile data.
- x0 is never forwarded and never causes a hazard.
- flush: next state EMPTY and the held entry is dropped. Flush has priority over capture and over hold. `id_ready` may be high during flush, but nothing is captured.
- EX-side stall (FULL, !ex_ready): the payload is held stable and bit-exact.
- Reset: EMPTY; ex_valid, alu_opt, alu_a_data, alu_b_data, ex_pc, ex_rd_addr, ex_rd_wen all 0. Reset mid-stall discards the entry.

## Timing
- Latency is one cycle from capture to ex_valid.
- Throughput is one instruction per cycle when there are no hazards.
- `id_ready` is combinational from ex_ready, flush-independent hazard terms, and MEM/WB inputs. There is no combinational path from id_valid to id_ready.
- ex_* outputs depend only on state; there is no combinational path from inputs.

## Configuration
- `YSYX_23060077_FORWARD_EN` defined: MEM/WB forwarding as above.
- Not defined: no forward mux; operands come from regfile data only. `id_ready` is additionally low while any used rs matches a pending writer in MEM or WB (wen, addr≠0). The regfile writes on the WB edge, so capture proceeds the cycle after WB.

## Structure
- Shared define file: DATA_WIDTH, ALU_OPT_WIDTH, REG_ADDR_WIDTH, ALU opcode constants (ALU_ADD etc.), and the A/B select encodings.
- Sub-module `ysyx_23060077_riscv_fwd_sel`: one instance per source operand. It outputs the forwarded data and a load-stall flag.

## Test plan
- Reset asserted mid-FULL with ex_ready=0 → ex_valid=0 and all payload 0 immediately; next id_valid captures normally.
- Back-to-back independent ADDIs with ex_ready=1 → one ex_valid per cycle; alu_b_data = imm (e.g. 0x7FF) and alu_a_data = rs1 data.
- `add x5,x1,x2` held, next `sub x6,x5,x3`:
  - With FORWARD_EN: id_ready low for 1 cycle, then alu_a_data = mem_rd_data (0x1234).
  - Without: stall until WB and regfile data are used.
- MEM holds a load to x7 and ID uses x7 → id_ready=0 until the load reaches WB; then alu_a_data = wb_rd_data.
- Both MEM and WB write x9 (0xAA / 0xBB) → operand = 0xAA. rd=x0 with wen=1 → no forward and no stall.
- flush coincident with a capture while FULL and ex_ready=0 → next cycle ex_valid=0 and the incoming instruction is not seen.
